// File: rtl/strobe_sequencer.sv
// strobe_sequencer
// Programmable trigger-to-strobe controller for the pixel front-end readout.
// An accepted trigger starts a sequence: wait (cfg_delay+1) cycles, then drive
// a strobe of D cycles, optionally repeated after G low cycles, for N strobes.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   trigger        trigger request (level, one trigger per cycle high)
//   abort          synchronous abort of a running sequence
//   cfg_delay      cycles from accept to strobe rise, minus one
//   cfg_duration   strobe high time (0 treated as 1)
//   cfg_gap        low time between strobes (0 treated as 1)
//   cfg_nstrobes   strobes per trigger (0 treated as 1)
//   strobe         registered strobe output
//   busy           high whenever the sequencer is not idle
//   strobe_id      increments on every strobe rise, wraps
//   trig_accepted  one-cycle pulse on an accepted trigger
//   trig_rejected  one-cycle pulse on a trigger seen while busy
//   rej_count      saturating count of rejected triggers
module strobe_sequencer #(
    parameter int CNT_WIDTH  = 16,
    parameter int NSTR_WIDTH = 4,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  cfg_delay,
    input  logic [CNT_WIDTH-1:0]  cfg_duration,
    input  logic [CNT_WIDTH-1:0]  cfg_gap,
    input  logic [NSTR_WIDTH-1:0] cfg_nstrobes,
    output logic                  strobe,
    output logic                  busy,
    output logic [ID_WIDTH-1:0]   strobe_id,
    output logic                  trig_accepted,
    output logic                  trig_rejected,
    output logic [CNT_WIDTH-1:0]  rej_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t                state_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [CNT_WIDTH-1:0]  dur_sh_r;
    logic [CNT_WIDTH-1:0]  gap_sh_r;
    logic [NSTR_WIDTH-1:0] nstr_rem_r;

    logic [CNT_WIDTH-1:0]  dur_eff_s;
    logic [CNT_WIDTH-1:0]  gap_eff_s;
    logic [NSTR_WIDTH-1:0] nstr_eff_s;

    // Zero-valued configuration fields are clamped to one before latching.
    assign dur_eff_s  = (cfg_duration == '0) ? CNT_WIDTH'(1)  : cfg_duration;
    assign gap_eff_s  = (cfg_gap == '0)      ? CNT_WIDTH'(1)  : cfg_gap;
    assign nstr_eff_s = (cfg_nstrobes == '0) ? NSTR_WIDTH'(1) : cfg_nstrobes;

    // Sequencer FSM with all outputs registered.
    // The phase counter is loaded with (length-1) and a phase ends on the
    // cycle it reads zero, so a phase of length L lasts exactly L cycles.
    // The delay phase is loaded with cfg_delay itself (not minus one), which
    // yields cfg_delay+1 cycles and never underflows at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            dur_sh_r      <= '0;
            gap_sh_r      <= '0;
            nstr_rem_r    <= '0;
            strobe        <= 1'b0;
            busy          <= 1'b0;
            strobe_id     <= '0;
            trig_accepted <= 1'b0;
            trig_rejected <= 1'b0;
            rej_count     <= '0;
        end else begin
            trig_accepted <= 1'b0;
            trig_rejected <= 1'b0;

            // Rejection is judged on the registered state, so a trigger in
            // the final strobe cycle or together with abort is rejected.
            if (trigger && (state_r != IDLE)) begin
                trig_rejected <= 1'b1;
                if (rej_count != '1) begin
                    rej_count <= rej_count + CNT_WIDTH'(1);
                end
            end

            if (abort && (state_r != IDLE)) begin
                state_r <= IDLE;
                strobe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (trigger) begin
                            dur_sh_r      <= dur_eff_s;
                            gap_sh_r      <= gap_eff_s;
                            nstr_rem_r    <= nstr_eff_s;
                            cnt_r         <= cfg_delay;
                            busy          <= 1'b1;
                            trig_accepted <= 1'b1;
                            state_r       <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (cnt_r == '0) begin
                            state_r   <= STROBE;
                            strobe    <= 1'b1;
                            cnt_r     <= dur_sh_r - CNT_WIDTH'(1);
                            strobe_id <= strobe_id + ID_WIDTH'(1);
                        end else begin
                            cnt_r <= cnt_r - CNT_WIDTH'(1);
                        end
                    end
                    STROBE: begin
                        if (cnt_r == '0) begin
                            strobe     <= 1'b0;
                            nstr_rem_r <= nstr_rem_r - NSTR_WIDTH'(1);
                            if (nstr_rem_r > NSTR_WIDTH'(1)) begin
                                state_r <= GAP;
                                cnt_r   <= gap_sh_r - CNT_WIDTH'(1);
                            end else begin
                                state_r <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            cnt_r <= cnt_r - CNT_WIDTH'(1);
                        end
                    end
                    GAP: begin
                        if (cnt_r == '0) begin
                            state_r   <= STROBE;
                            strobe    <= 1'b1;
                            cnt_r     <= dur_sh_r - CNT_WIDTH'(1);
                            strobe_id <= strobe_id + ID_WIDTH'(1);
                        end else begin
                            cnt_r <= cnt_r - CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        strobe  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
